// File: rtl/c17_resp_misr.sv
// MISR response compactor for the two C17 primary outputs, with a pass/fail verdict.
// Optional X-masking of response bits is enabled with `define C17_MISR_XMASK_EN.
module c17_resp_misr #(
  parameter int             SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h002D,
  parameter int             CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pat_count,
  input  logic             resp_valid,
  input  logic [1:0]       resp,
  output logic             resp_ready,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
`ifdef C17_MISR_XMASK_EN
  ,
  input  logic [1:0]       resp_xmask
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count_inc;
  logic [SIG_W-1:0] sig_next;
  logic [1:0]       r;
  logic             accept;
  logic             last;

`ifdef C17_MISR_XMASK_EN
  assign r = resp & ~resp_xmask;
`else
  assign r = resp;
`endif

  assign accept    = (state == RUN) && resp_valid && resp_ready;
  assign count_inc = count + CNT_W'(1);
  assign last      = accept && (count_inc == target);

  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-2){1'b0}}, r};

  // pass holds the signature/golden comparison taken on the DONE-entry edge,
  // so the verdict stays frozen with the signature while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      target     <= '0;
      signature  <= '0;
      resp_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature <= '0;
            count     <= '0;
            target    <= pat_count;
            if (pat_count == '0) begin
              state      <= DONE;
              resp_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (golden == '0);
            end else begin
              state      <= RUN;
              resp_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            signature <= sig_next;
            count     <= count_inc;
            if (last) begin
              state      <= DONE;
              resp_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (sig_next == golden);
            end
          end
        end
        default: begin
          state      <= IDLE;
          resp_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c17_resp_misr.sv
// Self-checking bench for c17_resp_misr: directed scenarios plus randomized sessions
// compared against a polynomial-arithmetic signature model.
module tb_c17_resp_misr;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pat_count;
  logic        resp_valid;
  logic [1:0]  resp;
  logic        resp_ready;
  logic [15:0] golden;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [1:0]  resp_xmask;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] beats_q[$];
  logic [1:0] masks_q[$];

  c17_resp_misr dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pat_count  (pat_count),
    .resp_valid (resp_valid),
    .resp       (resp),
    .resp_ready (resp_ready),
    .golden     (golden),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
`ifdef C17_MISR_XMASK_EN
    ,
    .resp_xmask (resp_xmask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Signature as repeated multiplication by x modulo the feedback polynomial,
  // plus the two response bits added into the low coefficients.
  function automatic logic [15:0] model_sig();
    int s;
    int rv;
    bit msb;
    s = 0;
    for (int i = 0; i < beats_q.size(); i++) begin
`ifdef C17_MISR_XMASK_EN
      rv = int'(beats_q[i] & ~masks_q[i]);
`else
      rv = int'(beats_q[i]);
`endif
      msb = (s >= 32768);
      s = (s * 2) % 65536;
      if (msb) s = s ^ 'h002D;
      s = s ^ rv;
    end
    return 16'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    beats_q.delete();
    masks_q.delete();
    for (int i = 0; i < n; i++) begin
      beats_q.push_back(2'($urandom));
      masks_q.push_back(2'($urandom));
    end
  endtask

  // Drives one full session from beats_q/masks_q; optional valid gaps with
  // junk data and stray start pulses that the DUT must ignore.
  task automatic feed_session(input int n, input logic [15:0] gold,
                              input bit gaps, input bit poke_start);
    pat_count = 16'(n);
    golden    = gold;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        resp_valid = 1'b0;
        resp       = 2'($urandom);
        resp_xmask = 2'($urandom);
        if (poke_start) begin
          start     = 1'b1;
          pat_count = 16'($urandom_range(0, 3));
        end
        tick();
        start     = 1'b0;
        pat_count = 16'(n);
      end
      resp_valid = 1'b1;
      resp       = beats_q[i];
      resp_xmask = masks_q[i];
      tick();
    end
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start      = 1'(($urandom));
      resp_valid = 1'(($urandom));
      resp       = 2'($urandom);
      pat_count  = 16'($urandom_range(1, 5));
      tick();
      n_checks++;
      if ({resp_ready, busy, done, pass, signature} !== 20'h0)
        $display("[TB] FAIL reset_outputs: got rdy=%b busy=%b done=%b pass=%b sig=%h, expected all 0",
                 resp_ready, busy, done, pass, signature);
      else n_pass++;
    end
    start = 1'b0; resp_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({resp_ready, busy, done} !== 3'b000)
      $display("[TB] FAIL reset_idle: got rdy=%b busy=%b done=%b, expected 000", resp_ready, busy, done);
    else n_pass++;

    pat_count = 16'd5; golden = 16'h0; start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 2'b01; tick();
    resp = 2'b11; tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({resp_ready, busy, done, signature} !== 19'h0)
      $display("[TB] FAIL reset_midrun: got rdy=%b busy=%b done=%b sig=%h, expected all 0",
               resp_ready, busy, done, signature);
    else n_pass++;
    tick(); tick();
    resp_valid = 1'b0;
    n_checks++;
    if ({busy, signature} !== 17'h0)
      $display("[TB] FAIL reset_no_accept: got busy=%b sig=%h, expected busy=0 sig=0000", busy, signature);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    pat_count = 16'd1; golden = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, resp_ready, done} !== 3'b110)
      $display("[TB] FAIL start_latency: got busy=%b rdy=%b done=%b, expected 110", busy, resp_ready, done);
    else n_pass++;
    resp_valid = 1'b1; resp = 2'b01; resp_xmask = 2'b00;
    tick();
    resp_valid = 1'b0;
    n_checks++;
    if ({done, pass, busy, resp_ready, signature} !== {4'b1100, 16'h0001})
      $display("[TB] FAIL single_pass: got done=%b pass=%b busy=%b rdy=%b sig=%h, expected 1100 sig=0001",
               done, pass, busy, resp_ready, signature);
    else n_pass++;

    beats_q = '{2'b01}; masks_q = '{2'b00};
    feed_session(1, 16'h0002, 1'b0, 1'b0);
    n_checks++;
    if ({done, pass, signature} !== {2'b10, 16'h0001})
      $display("[TB] FAIL single_fail: got done=%b pass=%b sig=%h, expected done=1 pass=0 sig=0001",
               done, pass, signature);
    else n_pass++;
  endtask

  task automatic test_two_beats();
    beats_q = '{2'b01, 2'b10}; masks_q = '{2'b00, 2'b00};
    feed_session(2, 16'h0000, 1'b0, 1'b0);
    n_checks++;
    if ({done, pass, signature} !== {2'b11, 16'h0000})
      $display("[TB] FAIL two_beats: got done=%b pass=%b sig=%h, expected done=1 pass=1 sig=0000",
               done, pass, signature);
    else n_pass++;
    resp_valid = 1'b1; resp = 2'b11; resp_xmask = 2'b00;
    n_checks++;
    if (resp_ready !== 1'b0)
      $display("[TB] FAIL extra_beat_ready: got rdy=%b, expected 0", resp_ready);
    else n_pass++;
    tick(); tick();
    resp_valid = 1'b0;
    n_checks++;
    if ({done, pass, signature} !== {2'b11, 16'h0000})
      $display("[TB] FAIL extra_beat_ignored: got done=%b pass=%b sig=%h, expected done=1 pass=1 sig=0000",
               done, pass, signature);
    else n_pass++;
  endtask

  task automatic test_feedback();
    pat_count = 16'd17; golden = 16'h002D; start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp_xmask = 2'b00;
    for (int i = 0; i < 16; i++) begin
      resp = (i == 0) ? 2'b01 : 2'b00;
      tick();
    end
    n_checks++;
    if ({done, signature} !== {1'b0, 16'h8000})
      $display("[TB] FAIL feedback_16: got done=%b sig=%h, expected done=0 sig=8000", done, signature);
    else n_pass++;
    resp = 2'b00;
    tick();
    resp_valid = 1'b0;
    n_checks++;
    if ({done, pass, signature} !== {2'b11, 16'h002D})
      $display("[TB] FAIL feedback_17: got done=%b pass=%b sig=%h, expected done=1 pass=1 sig=002d",
               done, pass, signature);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(5, 20);
      fill_random(n);
      exp = model_sig();
      feed_session(n, (k % 2 == 0) ? exp : exp ^ 16'h0100, 1'b1, 1'b1);
      n_checks++;
      if ({done, busy, signature, pass} !== {2'b10, exp, (k % 2 == 0)})
        $display("[TB] FAIL backpressure_%0d: got done=%b busy=%b sig=%h pass=%b, expected done=1 busy=0 sig=%h pass=%b",
                 k, done, busy, signature, pass, exp, (k % 2 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_zero_count();
    beats_q.delete(); masks_q.delete();
    feed_session(0, 16'h0000, 1'b0, 1'b0);
    n_checks++;
    if ({done, busy, resp_ready, pass, signature} !== {4'b1001, 16'h0000})
      $display("[TB] FAIL zero_count_pass: got done=%b busy=%b rdy=%b pass=%b sig=%h, expected 1001 sig=0000",
               done, busy, resp_ready, pass, signature);
    else n_pass++;
    feed_session(0, 16'h1234, 1'b0, 1'b0);
    n_checks++;
    if ({done, pass, signature} !== {2'b10, 16'h0000})
      $display("[TB] FAIL zero_count_fail: got done=%b pass=%b sig=%h, expected done=1 pass=0 sig=0000",
               done, pass, signature);
    else n_pass++;
  endtask

  task automatic test_xmask();
    logic [15:0] exp;
    beats_q = '{2'b11}; masks_q = '{2'b10};
`ifdef C17_MISR_XMASK_EN
    exp = 16'h0001;
`else
    exp = 16'h0003;
`endif
    feed_session(1, exp, 1'b0, 1'b0);
    n_checks++;
    if ({done, pass, signature} !== {2'b11, exp})
      $display("[TB] FAIL xmask: got done=%b pass=%b sig=%h, expected done=1 pass=1 sig=%h",
               done, pass, signature, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_random(n);
      exp = model_sig();
      feed_session(n, exp, 1'b0, 1'b0);
      n_checks++;
      if ({done, pass, signature} !== {2'b11, exp})
        $display("[TB] FAIL back_to_back_%0d: got done=%b pass=%b sig=%h, expected done=1 pass=1 sig=%h",
                 k, done, pass, signature, exp);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pat_count = '0; resp_valid = 1'b0;
    resp = '0; golden = '0; resp_xmask = '0;
    test_reset();
    test_single_beat();
    test_two_beats();
    test_feedback();
    test_backpressure();
    test_zero_count();
    test_xmask();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
